// File: rtl/regfile_dump_reader_pkg.sv
// rtl/regfile_dump_reader_pkg.sv - shared constants, state encoding and index helper for the dump reader
package regfile_dump_reader_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_t;

  // Step to the next register index, wrapping at NUM_REGS so a range such as
  // 14..1 walks 14, 15, 0, 1.
  function automatic logic [ADDR_W-1:0] next_index(input logic [ADDR_W-1:0] cur);
    if (cur == ADDR_W'(NUM_REGS - 1)) begin
      return '0;
    end
    return cur + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// rtl/regfile_dump_reader_if.sv - {index, data} word stream from the dump reader to the debug consumer
interface regfile_dump_reader_if;
  import regfile_dump_reader_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_index;
  logic [DATA_W-1:0] out_data;

  modport master (
    output out_valid,
    output out_index,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_index,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a register index range, streams each value, finishes with an XOR checksum
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     first_reg,
  input  logic [ADDR_W-1:0]     last_reg,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  regfile_dump_reader_if.master dump_stream,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     checksum
);

  dump_state_t       r_state;
  dump_state_t       w_next;
  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_end;
  logic [ADDR_W-1:0] r_out_index;
  logic [DATA_W-1:0] r_out_data;
  logic [DATA_W-1:0] r_checksum;
  logic              w_handshake;
  logic              w_last;

  assign w_handshake = (r_state == ST_SEND) && dump_stream.out_ready;
  assign w_last      = (r_cur == r_end);

  // Next-state decode: one READ/SEND pair per word, single DONE cycle at the end.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_READ;
      ST_READ: w_next = ST_SEND;
      ST_SEND: if (w_handshake) w_next = w_last ? ST_DONE : ST_READ;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State register; reset aborts any dump in progress without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Range bookkeeping, per-word snapshot and running checksum.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur       <= '0;
      r_end       <= '0;
      r_out_index <= '0;
      r_out_data  <= '0;
      r_checksum  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cur      <= first_reg;
            r_end      <= last_reg;
            r_checksum <= '0;
          end
        end
        ST_READ: begin
          // Snapshot taken here; a write landing on this same edge is not seen.
          r_out_data  <= rd_data;
          r_out_index <= r_cur;
        end
        ST_SEND: begin
          if (w_handshake) begin
            r_checksum <= r_checksum ^ r_out_data;
            if (!w_last) begin
              r_cur <= next_index(r_cur);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rd_addr               = (r_state == ST_IDLE) ? '0 : r_cur;
  assign dump_stream.out_valid = (r_state == ST_SEND);
  assign dump_stream.out_index = r_out_index;
  assign dump_stream.out_data  = r_out_data;
  assign busy                  = (r_state == ST_READ) || (r_state == ST_SEND);
  assign done                  = (r_state == ST_DONE);
  assign checksum              = r_checksum;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - directed bench for the register file dump reader
module tb_regfile_dump_reader;
  import regfile_dump_reader_pkg::*;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] first_reg;
  logic [ADDR_W-1:0] last_reg;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;

  logic              preload;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] regs [NUM_REGS];

  int n_vec;
  int n_err;

  logic [ADDR_W-1:0] cap_idx[$];
  logic [DATA_W-1:0] cap_data[$];
  logic [DATA_W-1:0] held[$];
  int                done_k;
  int                first_valid_k;
  logic [DATA_W-1:0] done_checksum;
  logic              post_busy;
  logic              post_done;
  logic [DATA_W-1:0] post_checksum;

  regfile_dump_reader_if dump_if ();

  regfile_dump_reader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .first_reg   (first_reg),
    .last_reg    (last_reg),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .dump_stream (dump_if.master),
    .busy        (busy),
    .done        (done),
    .checksum    (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file: preload rN = N, otherwise one synchronous write port.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= DATA_W'(i);
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rd_data = regs[rd_addr];

  // Issues start at cycle T (a negedge), then watches cycles T+1.. until done.
  task automatic run_dump(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l,
                          input int stall_index, input int stall_len,
                          input int restart_k, input int wr_index, input bit start_at_done);
    int stalled;
    bit wrote;
    bit finished;
    stalled  = 0;
    wrote    = 1'b0;
    finished = 1'b0;
    cap_idx.delete();
    cap_data.delete();
    held.delete();
    done_k        = -1;
    first_valid_k = -1;
    done_checksum = '0;
    @(negedge clk);
    start     = 1'b1;
    first_reg = f;
    last_reg  = l;
    dump_if.out_ready = 1'b1;
    for (int k = 1; k <= 200 && !finished; k++) begin
      @(negedge clk);
      start = 1'b0;
      we    = 1'b0;
      if (k == restart_k) begin
        start     = 1'b1;
        first_reg = 4'd9;
        last_reg  = 4'd9;
      end
      if (dump_if.out_valid && first_valid_k < 0) first_valid_k = k;
      if (wr_index >= 0 && !wrote && busy && !dump_if.out_valid && int'(rd_addr) == wr_index) begin
        we    = 1'b1;
        waddr = ADDR_W'(wr_index);
        wdata = 16'hBEEF;
        wrote = 1'b1;
      end
      dump_if.out_ready = 1'b1;
      if (dump_if.out_valid && int'(dump_if.out_index) == stall_index && stalled < stall_len) begin
        dump_if.out_ready = 1'b0;
        held.push_back(dump_if.out_data);
        stalled++;
      end
      if (dump_if.out_valid && dump_if.out_ready) begin
        cap_idx.push_back(dump_if.out_index);
        cap_data.push_back(dump_if.out_data);
      end
      if (done) begin
        done_k        = k;
        done_checksum = checksum;
        finished      = 1'b1;
        if (start_at_done) start = 1'b1;
      end
    end
    @(negedge clk);
    start         = 1'b0;
    we            = 1'b0;
    post_busy     = busy;
    post_done     = done;
    post_checksum = checksum;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    preload = 1'b1;
    start   = 1'b0;
    we      = 1'b0;
    waddr   = '0;
    wdata   = '0;
    first_reg = '0;
    last_reg  = '0;
    dump_if.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (dump_if.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", dump_if.out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
    n_vec++; if (dump_if.out_index !== 4'd0) begin n_err++; $display("FAIL reset_out_index got %0d exp 0", dump_if.out_index); end
    n_vec++; if (dump_if.out_data !== 16'h0000) begin n_err++; $display("FAIL reset_out_data got %h exp 0000", dump_if.out_data); end
    n_vec++; if (checksum !== 16'h0000) begin n_err++; $display("FAIL reset_checksum got %h exp 0000", checksum); end
    n_vec++; if (rd_addr !== 4'd0) begin n_err++; $display("FAIL reset_rd_addr got %0d exp 0", rd_addr); end
    reset   = 1'b0;
    preload = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_range();
    run_dump(4'd0, 4'd15, -1, 0, -1, -1, 1'b0);
    n_vec++; if (cap_idx.size() != 16) begin n_err++; $display("FAIL full_count got %0d exp 16", cap_idx.size()); end
    for (int i = 0; i < 16 && i < cap_idx.size(); i++) begin
      n_vec++; if (cap_idx[i] !== 4'(i) || cap_data[i] !== 16'(i)) begin
        n_err++; $display("FAIL full_word%0d got idx %0d data %h exp idx %0d data %h", i, cap_idx[i], cap_data[i], i, 16'(i));
      end
    end
    n_vec++; if (first_valid_k != 2) begin n_err++; $display("FAIL full_first_valid got T+%0d exp T+2", first_valid_k); end
    n_vec++; if (done_k != 33) begin n_err++; $display("FAIL full_done_cycle got T+%0d exp T+33", done_k); end
    n_vec++; if (done_checksum !== 16'h0000) begin n_err++; $display("FAIL full_checksum got %h exp 0000", done_checksum); end
    n_vec++; if (post_done !== 1'b0 || post_busy !== 1'b0) begin n_err++; $display("FAIL full_done_pulse got done %b busy %b exp 0 0", post_done, post_busy); end
    n_vec++; if (rd_addr !== 4'd0) begin n_err++; $display("FAIL full_idle_rd_addr got %0d exp 0", rd_addr); end
  endtask

  task automatic test_backpressure();
    run_dump(4'd3, 4'd5, 4, 4, -1, -1, 1'b0);
    n_vec++; if (held.size() != 4) begin n_err++; $display("FAIL bp_stall_cycles got %0d exp 4", held.size()); end
    for (int i = 0; i < held.size(); i++) begin
      n_vec++; if (held[i] !== 16'h0004) begin n_err++; $display("FAIL bp_held%0d got %h exp 0004", i, held[i]); end
    end
    n_vec++; if (cap_idx.size() != 3) begin n_err++; $display("FAIL bp_count got %0d exp 3", cap_idx.size()); end
    else begin
      n_vec++; if (cap_data[0] !== 16'd3 || cap_data[1] !== 16'd4 || cap_data[2] !== 16'd5) begin
        n_err++; $display("FAIL bp_words got %h %h %h exp 0003 0004 0005", cap_data[0], cap_data[1], cap_data[2]);
      end
    end
    n_vec++; if (done_k != 11) begin n_err++; $display("FAIL bp_done_cycle got T+%0d exp T+11", done_k); end
    n_vec++; if (done_checksum !== 16'h0002) begin n_err++; $display("FAIL bp_checksum got %h exp 0002", done_checksum); end
    n_vec++; if (post_checksum !== 16'h0002) begin n_err++; $display("FAIL bp_checksum_hold got %h exp 0002", post_checksum); end
  endtask

  task automatic test_wrap();
    run_dump(4'd14, 4'd1, -1, 0, -1, -1, 1'b0);
    n_vec++; if (cap_idx.size() != 4) begin n_err++; $display("FAIL wrap_count got %0d exp 4", cap_idx.size()); end
    else begin
      n_vec++; if (cap_idx[0] !== 4'd14 || cap_idx[1] !== 4'd15 || cap_idx[2] !== 4'd0 || cap_idx[3] !== 4'd1) begin
        n_err++; $display("FAIL wrap_order got %0d %0d %0d %0d exp 14 15 0 1", cap_idx[0], cap_idx[1], cap_idx[2], cap_idx[3]);
      end
    end
    n_vec++; if (done_checksum !== 16'h0000) begin n_err++; $display("FAIL wrap_checksum got %h exp 0000", done_checksum); end
  endtask

  task automatic test_single();
    run_dump(4'd7, 4'd7, -1, 0, -1, -1, 1'b1);
    n_vec++; if (cap_idx.size() != 1) begin n_err++; $display("FAIL single_count got %0d exp 1", cap_idx.size()); end
    else begin
      n_vec++; if (cap_idx[0] !== 4'd7 || cap_data[0] !== 16'h0007) begin
        n_err++; $display("FAIL single_word got idx %0d data %h exp idx 7 data 0007", cap_idx[0], cap_data[0]);
      end
    end
    n_vec++; if (done_k != 3) begin n_err++; $display("FAIL single_done_cycle got T+%0d exp T+3", done_k); end
    n_vec++; if (done_checksum !== 16'h0007) begin n_err++; $display("FAIL single_checksum got %h exp 0007", done_checksum); end
    n_vec++; if (post_busy !== 1'b0) begin n_err++; $display("FAIL single_start_in_done got busy %b exp 0", post_busy); end
  endtask

  task automatic test_restart_and_abort();
    bit saw;
    run_dump(4'd2, 4'd4, -1, 0, 3, -1, 1'b0);
    n_vec++; if (cap_idx.size() != 3) begin n_err++; $display("FAIL restart_count got %0d exp 3", cap_idx.size()); end
    else begin
      n_vec++; if (cap_idx[0] !== 4'd2 || cap_idx[1] !== 4'd3 || cap_idx[2] !== 4'd4) begin
        n_err++; $display("FAIL restart_order got %0d %0d %0d exp 2 3 4", cap_idx[0], cap_idx[1], cap_idx[2]);
      end
    end
    n_vec++; if (done_checksum !== 16'h0005) begin n_err++; $display("FAIL restart_checksum got %h exp 0005", done_checksum); end
    n_vec++; if (post_busy !== 1'b0) begin n_err++; $display("FAIL restart_idle_after got busy %b exp 0", post_busy); end
    @(negedge clk);
    start     = 1'b1;
    first_reg = 4'd0;
    last_reg  = 4'd15;
    dump_if.out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_vec++; if (dump_if.out_valid !== 1'b1) begin n_err++; $display("FAIL abort_in_send got out_valid %b exp 1", dump_if.out_valid); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++; if (dump_if.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL abort_outputs got valid %b busy %b done %b exp 0 0 0", dump_if.out_valid, busy, done);
    end
    n_vec++; if (rd_addr !== 4'd0 || checksum !== 16'h0000) begin
      n_err++; $display("FAIL abort_regs got rd_addr %0d checksum %h exp 0 0000", rd_addr, checksum);
    end
    dump_if.out_ready = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) saw = 1'b1;
    end
    n_vec++; if (saw) begin n_err++; $display("FAIL abort_quiet got activity 1 exp 0"); end
  endtask

  task automatic test_snapshot();
    run_dump(4'd3, 4'd5, -1, 0, -1, 4, 1'b0);
    n_vec++; if (cap_data.size() != 3) begin n_err++; $display("FAIL snap_count got %0d exp 3", cap_data.size()); end
    else begin
      n_vec++; if (cap_data[1] !== 16'h0004) begin n_err++; $display("FAIL snap_old_value got %h exp 0004", cap_data[1]); end
    end
    n_vec++; if (done_checksum !== 16'h0002) begin n_err++; $display("FAIL snap_checksum got %h exp 0002", done_checksum); end
    run_dump(4'd4, 4'd4, -1, 0, -1, -1, 1'b0);
    n_vec++; if (cap_data.size() != 1) begin n_err++; $display("FAIL snap2_count got %0d exp 1", cap_data.size()); end
    else begin
      n_vec++; if (cap_data[0] !== 16'hBEEF) begin n_err++; $display("FAIL snap2_new_value got %h exp beef", cap_data[0]); end
    end
    n_vec++; if (done_checksum !== 16'hBEEF) begin n_err++; $display("FAIL snap2_checksum got %h exp beef", done_checksum); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_full_range();
    test_backpressure();
    test_wrap();
    test_single();
    test_restart_and_abort();
    test_snapshot();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
